// File: rtl/pes_tlc_farm_req.sv
// Farm-road request generator: debounces the loop detector, counts waiting
// cars, drives the controller's C input and flags unsafe light combinations.
module pes_tlc_farm_req #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_raw,
    input  logic [2:0]       light_highway,
    input  logic [2:0]       light_farm,
    output logic             C,
    output logic [CNT_W-1:0] car_count,
    output logic             conflict_err
);

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       STAB_END = 4'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } state_t;

    logic       sync_q1;
    logic       sync_q2;
    logic [3:0] stab_cnt;
    logic       car_present;
    logic       car_present_q;
    logic       arrival;
    logic       farm_green;
    logic       light_bad;
    state_t     state;
    state_t     state_nxt;

    assign arrival    = car_present & ~car_present_q;
    assign farm_green = (light_farm == GREEN);

    // Unsafe when neither road shows red, or either vector is malformed.
    assign light_bad = ((light_highway != RED) && (light_farm != RED))
                     || !(light_highway inside {GREEN, YELLOW, RED})
                     || !(light_farm inside {GREEN, YELLOW, RED});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= car_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt      <= 4'd0;
            car_present   <= 1'b0;
            car_present_q <= 1'b0;
        end else begin
            car_present_q <= car_present;
            if (sync_q2 != car_present) begin
                if (stab_cnt == STAB_END) begin
                    car_present <= sync_q2;
                    stab_cnt    <= 4'd0;
                end else begin
                    stab_cnt <= stab_cnt + 4'd1;
                end
            end else begin
                stab_cnt <= 4'd0;
            end
        end
    end

    // A farm green lets waiting and arriving cars straight through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_count <= '0;
        end else if (farm_green) begin
            car_count <= '0;
        end else if (arrival && (car_count != CNT_MAX)) begin
            car_count <= car_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (farm_green) state_nxt = GRANT;
                else if (car_count != '0) state_nxt = REQ;
            end
            REQ: begin
                if (farm_green) state_nxt = GRANT;
            end
            GRANT: begin
                if ((light_farm == RED) && (light_highway == GREEN))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            C     <= 1'b0;
        end else begin
            state <= state_nxt;
            C     <= (state_nxt == REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_err <= 1'b0;
        end else if (light_bad) begin
            conflict_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pes_tlc_farm_req.sv
// Randomized and directed bench for pes_tlc_farm_req against a
// behavioural model of the request rules.
module tb_pes_tlc_farm_req;

    localparam int DEB  = 4;
    localparam int CMAX = 15;

    logic       clk;
    logic       rst_n;
    logic       car_raw;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       C;
    logic [3:0] car_count;
    logic       conflict_err;

    int n_cmp;
    int n_err;

    pes_tlc_farm_req #(.DEBOUNCE_CYC(DEB), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .car_raw      (car_raw),
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .C            (C),
        .car_count    (car_count),
        .conflict_err (conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: detector history, debounced level, waiting cars,
    // and whether a request is outstanding or being served.
    bit m_hist[$];
    bit m_level;
    bit m_level_prev;
    int m_run;
    int m_cars;
    int m_phase;
    bit m_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {1'b0, 1'b0};
        m_level = 0;
        m_level_prev = 0;
        m_run = 0;
        m_cars = 0;
        m_phase = 0;
        m_err = 0;
    endtask

    task automatic model_edge();
        bit seen;
        bit arrived;
        int cars_old;
        seen = m_hist[0];
        arrived = m_level && !m_level_prev;
        cars_old = m_cars;
        if ((light_highway != 3'b100 && light_farm != 3'b100) ||
            !$onehot(light_highway) || !$onehot(light_farm))
            m_err = 1;
        if (light_farm == 3'b001) m_cars = 0;
        else if (arrived) m_cars = (m_cars + 1 > CMAX) ? CMAX : m_cars + 1;
        // phase: 0 quiet, 1 requesting, 2 served
        if (m_phase == 2) begin
            if (light_farm == 3'b100 && light_highway == 3'b001) m_phase = 0;
        end else if (light_farm == 3'b001) begin
            m_phase = 2;
        end else if (m_phase == 0 && cars_old != 0) begin
            m_phase = 1;
        end
        m_level_prev = m_level;
        if (seen != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = seen;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        void'(m_hist.pop_front());
        m_hist.push_back(car_raw);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge();
        chk("C", int'(C), int'(m_phase == 1));
        chk("car_count", int'(car_count), m_cars);
        chk("conflict_err", int'(conflict_err), int'(m_err));
    endtask

    task automatic cycs(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_lights(input logic [2:0] hw, input logic [2:0] fm);
        light_highway = hw;
        light_farm = fm;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        car_raw = 1'b0;
        set_lights(3'b001, 3'b100);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_C", int'(C), 0);
        chk("rst_cnt", int'(car_count), 0);
        chk("rst_err", int'(conflict_err), 0);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int hi, input int lo);
        car_raw = 1'b1;
        cycs(hi);
        car_raw = 1'b0;
        cycs(lo);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        hard_reset();
        cycs(5);

        pulse(3, 10);
        chk("glitch_cnt", int'(car_count), 0);
        chk("glitch_C", int'(C), 0);

        car_raw = 1'b1;
        cycs(7);
        chk("single_cnt", int'(car_count), 1);
        cyc();
        chk("single_C", int'(C), 1);
        cycs(2);
        car_raw = 1'b0;
        cycs(6);
        chk("single_hold", int'(C), 1);
        set_lights(3'b100, 3'b001);
        cyc();
        chk("grant_cnt", int'(car_count), 0);
        chk("grant_C", int'(C), 0);
        cycs(3);
        set_lights(3'b100, 3'b010);
        pulse(8, 8);
        chk("late_cnt", int'(car_count), 1);
        chk("late_C0", int'(C), 0);
        set_lights(3'b001, 3'b100);
        cyc();
        chk("late_C1", int'(C), 0);
        cyc();
        chk("late_C2", int'(C), 1);
        chk("late_cnt2", int'(car_count), 1);

        set_lights(3'b001, 3'b001);
        cyc();
        chk("conflict_set", int'(conflict_err), 1);
        set_lights(3'b001, 3'b100);
        cycs(5);
        chk("conflict_stick", int'(conflict_err), 1);

        hard_reset();
        cycs(3);
        for (int i = 0; i < 20; i++) pulse(7, 7);
        chk("sat_cnt", int'(car_count), CMAX);
        chk("sat_C", int'(C), 1);

        hard_reset();
        begin
            int hold_car;
            int hold_lt;
            hold_car = 0;
            hold_lt = 0;
            for (int i = 0; i < 4000; i++) begin
                if (hold_car == 0) begin
                    car_raw = $urandom_range(1, 0);
                    hold_car = $urandom_range(12, 1);
                end
                if (hold_lt == 0) begin
                    hold_lt = $urandom_range(40, 3);
                    case ($urandom_range(40, 0))
                        0: set_lights(3'($urandom), 3'($urandom));
                        1, 2, 3, 4, 5, 6, 7, 8: set_lights(3'b001, 3'b100);
                        9, 10, 11, 12: set_lights(3'b010, 3'b100);
                        13, 14, 15, 16, 17: set_lights(3'b100, 3'b100);
                        18, 19, 20, 21, 22, 23, 24: set_lights(3'b100, 3'b001);
                        default: set_lights(3'b100, 3'b010);
                    endcase
                end
                hold_car--;
                hold_lt--;
                cyc();
            end
        end

        hard_reset();
        cycs(3);
        car_raw = 1'b1;
        cycs(9);
        car_raw = 1'b0;
        chk("pre_rst_C", int'(C), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_C", int'(C), 0);
        chk("async_cnt", int'(car_count), 0);
        chk("async_err", int'(conflict_err), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cycs(20);
        chk("post_rst_C", int'(C), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pes_tlc_farm_req.md
PES_TLC_FARM_REQ -- requirements
Module: pes_tlc_farm_req

Farm-road request generator. It conditions the raw farm-road vehicle detector and drives the sensor input C of the traffic-light controller. It also watches the controller's light outputs to know when the request has been served.

Light encoding (both roads): 3'b001 = green, 3'b010 = yellow, 3'b100 = red.

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: number of consecutive stable synchronized cycles (1..15) needed to change the debounced detector level.
REQ-002 Parameter CNT_W, default 4: width of the waiting-vehicle counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port car_raw, input, 1: raw loop detector, asynchronous to clk, may glitch.
REQ-006 Port light_highway, input, 3: highway light currently driven by the controller.
REQ-007 Port light_farm, input, 3: farm light currently driven by the controller.
REQ-008 Port C, output, 1: registered farm-road vehicle request to the controller.
REQ-009 Port car_count, output, CNT_W: registered count of vehicles waiting on the farm road.
REQ-010 Port conflict_err, output, 1: registered, sticky light-safety violation flag.

Function
REQ-011 car_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debouncer SHALL keep an internal level car_present, reset value 0.
- car_present toggles only after the synchronized input has differed from it for DEBOUNCE_CYC consecutive cycles.
- Any cycle of agreement clears the stability counter.
REQ-013 An arrival SHALL be the cycle in which car_present rises; exactly one arrival per debounced pulse.
REQ-014 Counter behaviour:
- car_count SHALL increment on the clock edge following an arrival.
- car_count SHALL saturate at 2^CNT_W-1; no wrap.
REQ-015 While light_farm == 3'b001, car_count SHALL be forced to 0 and arrivals SHALL be ignored (vehicles pass straight through).
REQ-016 Arrivals while light_farm is yellow or red SHALL be counted.
REQ-017 The FSM SHALL have three states: IDLE (C=0), REQ (C=1), GRANT (C=0). C is a registered decode of the state.
REQ-018 IDLE -> REQ on the edge where car_count != 0 and light_farm != 3'b001.
- C therefore rises one cycle after car_count first becomes nonzero.
REQ-019 REQ -> GRANT on the first edge where light_farm == 3'b001.
- In REQ, C SHALL stay 1 regardless of how long the grant takes.
REQ-020 GRANT -> IDLE on the edge where light_farm == 3'b100 and light_highway == 3'b001.
- If car_count != 0 at that point, the following cycle moves IDLE -> REQ per REQ-018.
REQ-021 If light_farm == 3'b001 is seen in IDLE (an unrequested grant), the FSM SHALL go to GRANT.
REQ-022 conflict_err SHALL be set on the edge after any cycle in which either of these holds:
- both light_highway != 3'b100 and light_farm != 3'b100; or
- either light vector is not exactly one-hot.
REQ-023 conflict_err SHALL remain 1 until reset. It SHALL NOT alter FSM or counter behaviour.
REQ-024 Simultaneous arrival and the REQ -> GRANT transition: the forcing rule of REQ-015 takes priority, so the count is 0.

Reset
REQ-025 While rst_n = 0, the following SHALL be held asynchronously:
- C = 0, car_count = 0, conflict_err = 0;
- FSM = IDLE, car_present = 0;
- synchronizer flops, stability counter and saturation logic cleared.
REQ-026 Reset asserted mid-REQ or mid-GRANT SHALL drop C to 0 immediately, without waiting for a clock edge.
REQ-027 After rst_n rises, the block SHALL apply normal behaviour from the first clock edge. No arrival is generated unless car_raw is debounced high anew.

Verification
REQ-028 Glitch reject (DEBOUNCE_CYC=4): car_raw high 3 cycles, then low -> car_count stays 0, C stays 0.
REQ-029 Single car: car_raw held high 10 cycles, lights highway=001, farm=100 ->
- car_present rises 2+4 cycles after the car_raw edge; car_count=1 on the next edge; C=1 one edge later.
- Then drive farm=001 -> car_count=0 and C=0 on the next edge.
- Then drive farm=100, highway=001 -> FSM returns to IDLE with C=0.
REQ-030 Saturation: 20 debounced pulses while farm=100 -> car_count=15, C=1 throughout.
REQ-031 Late arrival: pulse counted while farm=010 in GRANT -> on return to highway=001/farm=100, car_count=1 and C reasserts two edges later.
REQ-032 Conflict: highway=001 and farm=001 for one cycle -> conflict_err=1 on the next edge; stays 1 after lights are legal; cleared only by rst_n=0.
REQ-033 Reset mid-request: rst_n pulsed low for a fraction of a cycle while in REQ -> C, car_count and conflict_err read 0 immediately; after release, C stays 0 until a new debounced arrival.
